// File: rtl/yakirouter_pkg.sv
// Shared types for the YakiRouter packet transmitter: widths, header layout,
// FSM state encoding and the running parity helper.
package yakirouter_pkg;

    localparam int DATA_W    = 8;
    localparam int LEN_W     = DATA_W - 2;
    localparam int DEST_W    = 2;
    localparam int BUF_DEPTH = (1 << LEN_W) - 1;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [DEST_W-1:0] dest;
    } header_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        HDR  = 3'd3,
        PAY  = 3'd4,
        PAR  = 3'd5,
        GAP  = 3'd6
    } tx_state_t;

    function automatic logic [DATA_W-1:0] calc_parity(input logic [DATA_W-1:0] acc,
                                                      input logic [DATA_W-1:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/yakirouter_pkt_tx_if.sv
// Host request/payload handshakes plus the router-facing channel of one transmitter.
// Handshakes: a transfer happens on a rising clock edge where vld and rdy are both 1; the
// host holds vld and its data stable until then, and rdy never depends on vld in the same cycle.
interface yakirouter_pkt_tx_if;
    import yakirouter_pkg::*;

    logic              i_req_vld;
    logic              o_req_rdy;
    logic [DEST_W-1:0] i_req_dest;
    logic [LEN_W-1:0]  i_req_len;
    logic              i_pl_vld;
    logic [DATA_W-1:0] i_pl_data;
    logic              o_pl_rdy;
    logic              o_ch_en;
    logic [DATA_W-1:0] o_data;
    logic              i_busy;
    logic              i_error;
    logic              o_done;
    logic              o_req_err;
    logic              o_timeout;
    logic              o_err_seen;

    modport master (
        output i_req_vld, i_req_dest, i_req_len, i_pl_vld, i_pl_data, i_busy, i_error,
        input  o_req_rdy, o_pl_rdy, o_ch_en, o_data, o_done, o_req_err, o_timeout, o_err_seen
    );

    modport slave (
        input  i_req_vld, i_req_dest, i_req_len, i_pl_vld, i_pl_data, i_busy, i_error,
        output o_req_rdy, o_pl_rdy, o_ch_en, o_data, o_done, o_req_err, o_timeout, o_err_seen
    );

endinterface

// File: rtl/yakirouter_pl_buf.sv
// Payload store for one packet: written in arrival order, read back in the same order.
// Pointers restart from zero on flush; a packet never exceeds the depth, so no wrap.
module yakirouter_pl_buf
    import yakirouter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [LEN_W-1:0]  wr_ptr,
    output logic [LEN_W-1:0]  rd_ptr
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + LEN_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + LEN_W'(1);
        end
    end

    // Combinational read so the byte can be registered onto o_data in the same cycle.
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/yakirouter_pkt_tx.sv
// Buffers one host packet, then streams header, payload and parity into a router input
// channel once the router is not busy. Every output is registered from the next state.
module yakirouter_pkt_tx
    import yakirouter_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    yakirouter_pkt_tx_if.slave tx,
    output tx_state_t          dbg_state
);

    localparam int              TMR_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    tx_state_t         state, state_next;
    header_t           hdr;
    logic [DATA_W-1:0] parity_acc;
    logic [TMR_W-1:0]  timer;
    logic              req_acc, pl_acc, wr_en, rd_en, flush, tmo_hit;
    logic [DATA_W-1:0] rd_data;
    logic [LEN_W-1:0]  wr_ptr, rd_ptr;
    logic              req_rdy_d, pl_rdy_d, ch_en_d, done_d, req_err_d, timeout_d;
    logic [DATA_W-1:0] data_d;

    assign req_acc   = tx.i_req_vld & tx.o_req_rdy;
    assign pl_acc    = tx.i_pl_vld & tx.o_pl_rdy;
    assign tmo_hit   = (state == WAIT) & tx.i_busy & (timer == TMR_LAST);
    assign wr_en     = (state == LOAD) & pl_acc;
    assign rd_en     = (state_next == PAY);
    assign flush     = req_acc | tmo_hit;
    assign dbg_state = state;

    yakirouter_pl_buf u_buf (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (tx.i_pl_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_acc && tx.i_req_len != '0) state_next = LOAD;
            LOAD: if (pl_acc && wr_ptr == hdr.len - LEN_W'(1)) state_next = WAIT;
            WAIT: begin
                if (!tx.i_busy)   state_next = HDR;
                else if (tmo_hit) state_next = IDLE;
            end
            HDR:  state_next = PAY;
            // rd_ptr has already advanced past the byte currently on o_data.
            PAY:  if (rd_ptr == hdr.len) state_next = PAR;
            PAR:  state_next = GAP;
            GAP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_rdy_d = (state_next == IDLE);
        pl_rdy_d  = (state_next == LOAD);
        ch_en_d   = (state_next == HDR) || (state_next == PAY) || (state_next == PAR);
        done_d    = (state_next == PAR);
        req_err_d = (state == IDLE) && req_acc && (tx.i_req_len == '0);
        timeout_d = tmo_hit;
        data_d    = '0;
        case (state_next)
            HDR:     data_d = hdr;
            PAY:     data_d = rd_data;
            PAR:     data_d = parity_acc;
            default: data_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tx.o_req_rdy <= 1'b0;
            tx.o_pl_rdy  <= 1'b0;
            tx.o_ch_en   <= 1'b0;
            tx.o_data    <= '0;
            tx.o_done    <= 1'b0;
            tx.o_req_err <= 1'b0;
            tx.o_timeout <= 1'b0;
        end else begin
            tx.o_req_rdy <= req_rdy_d;
            tx.o_pl_rdy  <= pl_rdy_d;
            tx.o_ch_en   <= ch_en_d;
            tx.o_data    <= data_d;
            tx.o_done    <= done_d;
            tx.o_req_err <= req_err_d;
            tx.o_timeout <= timeout_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hdr           <= '0;
            parity_acc    <= '0;
            timer         <= '0;
            tx.o_err_seen <= 1'b0;
        end else begin
            if (req_acc) begin
                hdr        <= '{len: tx.i_req_len, dest: tx.i_req_dest};
                parity_acc <= {tx.i_req_len, tx.i_req_dest};
            end else if (wr_en) begin
                parity_acc <= calc_parity(parity_acc, tx.i_pl_data);
            end

            if (state == WAIT) timer <= timer + TMR_W'(1);
            else               timer <= '0;

            // Router errors are only recorded while this channel is actually driving it.
            if (req_acc) begin
                tx.o_err_seen <= 1'b0;
            end else if (tx.i_error && (state == HDR || state == PAY || state == PAR)) begin
                tx.o_err_seen <= 1'b1;
            end
        end
    end

endmodule
